alu_issue_ctrl: RTL

//  Sequencer for the combinational ALU. Accepts 3-operand register

---
 rtl/alu_issue_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/writeback sequencer for the combinational ALU
// Register file, three-state issue FSM and host load/observe port.
module alu_issue_ctrl #(
  parameter int N  = 32,
  parameter int AW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [3+3*AW-1:0]   instr,
  output logic [2:0]          alu_opcode,
  output logic [N-1:0]        alu_op_a,
  output logic [N-1:0]        alu_op_b,
  input  logic [N-1:0]        alu_result,
  output logic                done,
  output logic [N-1:0]        done_data,
  output logic                err,
  input  logic                host_we,
  input  logic [AW-1:0]       host_addr,
  input  logic [N-1:0]        host_wdata,
  input  logic [AW-1:0]       dbg_addr,
  output logic [N-1:0]        dbg_data
);

  localparam int NREG = 2**AW;

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  state_t          state, state_nx;
  logic [N-1:0]    rf [NREG];
  logic [AW-1:0]   rd_q;
  logic [N-1:0]    result_q;
  logic [2:0]      i_op;
  logic [AW-1:0]   i_rd, i_rs1, i_rs2;
  logic            accept, wb_we;

  assign {i_op, i_rd, i_rs1, i_rs2} = instr;

  // alu_opcode holds the latched opcode through WB, so it selects writeback vs error
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    accept      = 1'b0;
    wb_we       = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    done_data   = '0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WB;
      WB: begin
        done     = 1'b1;
        state_nx = IDLE;
        if (alu_opcode <= 3'd5) begin
          wb_we     = 1'b1;
          done_data = result_q;
        end else begin
          err = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operands are read from pre-edge register contents; no host-write forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_op_a   <= '0;
      alu_op_b   <= '0;
      rd_q       <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        alu_opcode <= i_op;
        alu_op_a   <= rf[i_rs1];
        alu_op_b   <= rf[i_rs2];
        rd_q       <= i_rd;
      end
      if (state == ISSUE) result_q <= alu_result;
    end
  end

  // Writeback is assigned last so it wins over a same-cycle host write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (host_we) rf[host_addr] <= host_wdata;
      if (wb_we)   rf[rd_q]      <= result_q;
    end
  end

  assign dbg_data = rf[dbg_addr];

endmodule
